// File: rtl/vga_fb_wr_sched.sv
`default_nettype none
// ============================================================================
// vga_fb_wr_sched : CPU store FIFO + constant-fill engine, round-robin
//                   arbitrated onto the display memory write port.  Rev 1.0
// ============================================================================
module vga_fb_wr_sched #(
  parameter logic [31:0] FB_BASE    = 32'h0001_0000,
  parameter logic [31:0] REG_BASE   = 32'h0000_FF00,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IO_DataAddr,
  input  logic [31:0] IO_DataIn,
  input  logic        IO_DataWe,
  output logic        fifo_full,
  output logic        ovf,
  output logic        fill_busy,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_web
);
  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fifo_addr_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q, full_d, ovf_q, ovf_d, prio_cpu_q, prio_cpu_d;
  logic [31:0]      fill_addr_q, fill_addr_d, fill_data_q, fill_data_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d, remain_q, remain_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [31:0]      waddr_q, waddr_d, wdata_q, wdata_d;
  logic             web_q, web_d;

  logic       fb_hit, reg_hit, cfg_wr, go, ovf_clr;
  logic       cpu_req, fill_req, grant_cpu, grant_fill, push, drop;
  logic [7:0] reg_off;

  assign fb_hit  = IO_DataWe && (IO_DataAddr[31:16] == FB_BASE[31:16]);
  assign reg_hit = IO_DataWe && (IO_DataAddr[31:8] == REG_BASE[31:8]);
  assign reg_off = IO_DataAddr[7:0];
  assign go      = reg_hit && (reg_off == 8'h0C);
  assign ovf_clr = reg_hit && (reg_off == 8'h10);
  assign cfg_wr  = reg_hit && (state_q == S_IDLE);

  // prio_cpu_q names the source that wins the next contended cycle
  assign cpu_req    = (cnt_q != '0);
  assign fill_req   = (state_q == S_RUN);
  assign grant_cpu  = cpu_req && (!fill_req || prio_cpu_q);
  assign grant_fill = fill_req && !grant_cpu;
  assign push       = fb_hit && ((cnt_q != DEPTH_C) || grant_cpu);
  assign drop       = fb_hit && !push;

  always_comb begin
    wptr_d      = wptr_q + PTR_W'(push);
    rptr_d      = rptr_q + PTR_W'(grant_cpu);
    cnt_d       = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(grant_cpu);
    full_d      = (cnt_d == DEPTH_C);
    ovf_d       = drop || (ovf_q && !ovf_clr);
    prio_cpu_d  = (cpu_req && fill_req) ? grant_fill : prio_cpu_q;

    fill_addr_d = fill_addr_q;
    fill_cnt_d  = fill_cnt_q;
    fill_data_d = fill_data_q;
    if (cfg_wr) begin
      case (reg_off)
        8'h00:   fill_addr_d = IO_DataIn;
        8'h04:   fill_cnt_d  = IO_DataIn[CNT_W-1:0];
        8'h08:   fill_data_d = IO_DataIn;
        default: ;
      endcase
    end

    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    case (state_q)
      S_IDLE: begin
        if (go && (fill_cnt_q != '0)) begin
          cur_addr_d = fill_addr_q;
          remain_d   = fill_cnt_q;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (grant_fill) begin
          cur_addr_d = cur_addr_q + 32'd4;
          remain_d   = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    web_d   = grant_cpu || grant_fill;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_cpu) begin
      waddr_d = fifo_addr_q[rptr_q];
      wdata_d = fifo_data_q[rptr_q];
    end else if (grant_fill) begin
      waddr_d = cur_addr_q;
      wdata_d = fill_data_q;
    end
  end

  // FIFO storage carries no reset; occupancy alone defines validity
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= IO_DataAddr;
      fifo_data_q[wptr_q] <= IO_DataIn;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      prio_cpu_q  <= 1'b1;
      fill_addr_q <= '0;
      fill_cnt_q  <= '0;
      fill_data_q <= '0;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      web_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      prio_cpu_q  <= prio_cpu_d;
      fill_addr_q <= fill_addr_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_data_q <= fill_data_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      web_q       <= web_d;
    end
  end

  assign fifo_full = full_q;
  assign ovf       = ovf_q;
  assign fill_busy = (state_q == S_RUN);
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_web   = web_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_wr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_fb_wr_sched : directed vector table plus multi-cycle sequences.
// ============================================================================
module tb_vga_fb_wr_sched;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IO_DataAddr = '0;
  logic [31:0] IO_DataIn   = '0;
  logic        IO_DataWe   = 1'b0;
  logic        fifo_full, ovf, fill_busy, mem_web;
  logic [31:0] mem_waddr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  vga_fb_wr_sched dut (
    .CLK(CLK), .RST(RST),
    .IO_DataAddr(IO_DataAddr), .IO_DataIn(IO_DataIn), .IO_DataWe(IO_DataWe),
    .fifo_full(fifo_full), .ovf(ovf), .fill_busy(fill_busy),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_web(mem_web)
  );

  logic [31:0] cap_a[$];
  logic [31:0] cap_d[$];
  int          full_cnt = 0;

  always @(negedge CLK) begin
    if (mem_web === 1'b1) begin
      cap_a.push_back(mem_waddr);
      cap_d.push_back(mem_wdata);
    end
    if (fifo_full === 1'b1) full_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    IO_DataWe   = we;
    IO_DataAddr = a;
    IO_DataIn   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_web"},   mem_web,   0);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_full"},  fifo_full, 0);
    chk({tag, "_ovf"},   ovf,       0);
    chk({tag, "_busy"},  fill_busy, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        web;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        full;
    logic        ovf;
    logic        busy;
  } vec_t;

  vec_t tv[25];

  initial begin
    int base, n_fill, n_cpu, n_other, last_k, first_f, last_f, bad, k, fbase;
    bit src_prev, src_cur;

    // row outputs are sampled 1 ns after the edge that consumed the row's inputs
    tv[0]  = '{1'b1, 32'h0001_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,          32'h0,          1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0001_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0001_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 32'h0001_0100, 32'hA000_0000, 1'b0, 32'h0001_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 32'h0001_0104, 32'hA000_0001, 1'b1, 32'h0001_0100, 32'hA000_0000, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 32'h0001_0108, 32'hA000_0002, 1'b1, 32'h0001_0104, 32'hA000_0001, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 32'h0001_010C, 32'hA000_0003, 1'b1, 32'h0001_0108, 32'hA000_0002, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 32'h0001_0110, 32'hA000_0004, 1'b1, 32'h0001_010C, 32'hA000_0003, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 32'h0001_0114, 32'hA000_0005, 1'b1, 32'h0001_0110, 32'hA000_0004, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0001_0114, 32'hA000_0005, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0001_0114, 32'hA000_0005, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 32'h0000_FF00, 32'h0001_0000, 1'b0, 32'h0001_0114, 32'hA000_0005, 1'b0, 1'b0, 1'b0};
    tv[12] = '{1'b1, 32'h0000_FF04, 32'h0000_0003, 1'b0, 32'h0001_0114, 32'hA000_0005, 1'b0, 1'b0, 1'b0};
    tv[13] = '{1'b1, 32'h0000_FF08, 32'h00FF_00FF, 1'b0, 32'h0001_0114, 32'hA000_0005, 1'b0, 1'b0, 1'b0};
    tv[14] = '{1'b1, 32'h0000_FF0C, 32'h0,         1'b0, 32'h0001_0114, 32'hA000_0005, 1'b0, 1'b0, 1'b1};
    tv[15] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0001_0000, 32'h00FF_00FF, 1'b0, 1'b0, 1'b1};
    tv[16] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0001_0004, 32'h00FF_00FF, 1'b0, 1'b0, 1'b1};
    tv[17] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    tv[18] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    // count bits above CNT_W are discarded, so this GO sees a zero count
    tv[19] = '{1'b1, 32'h0000_FF04, 32'hFFF0_0000, 1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    tv[20] = '{1'b1, 32'h0000_FF0C, 32'h0000_0001, 1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    tv[21] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    tv[22] = '{1'b1, 32'h0002_0000, 32'h1234_5678, 1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    tv[23] = '{1'b1, 32'h0000_FE00, 32'hCAFE_F00D, 1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};
    tv[24] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0001_0008, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0};

    #1 RST = 1'b1;
    #1 chk_zero("rst_async");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk_zero("rst_held");
    RST = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tv[i].we, tv[i].a, tv[i].d);
      chk($sformatf("v%0d_web", i),   mem_web,   tv[i].web);
      chk($sformatf("v%0d_waddr", i), mem_waddr, tv[i].wa);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].wd);
      chk($sformatf("v%0d_full", i),  fifo_full, tv[i].full);
      chk($sformatf("v%0d_ovf", i),   ovf,       tv[i].ovf);
      chk($sformatf("v%0d_busy", i),  fill_busy, tv[i].busy);
    end

    // fill of 8 beats against a CPU store every cycle
    step(1'b1, 32'h0000_FF00, 32'h0001_2000);
    step(1'b1, 32'h0000_FF04, 32'h0000_0008);
    step(1'b1, 32'h0000_FF08, 32'h5A5A_5A5A);
    base  = cap_a.size();
    fbase = full_cnt;
    step(1'b1, 32'h0000_FF0C, 32'h0);
    for (int j = 0; j < 14; j++) step(1'b1, 32'h0001_3000 + 32'(4 * j), 32'hC000_0000 + 32'(j));
    for (int j = 0; j < 12; j++) step(1'b0, 32'h0, 32'h0);

    n_fill = 0; n_cpu = 0; n_other = 0; last_k = -1; first_f = -1; last_f = -1;
    for (int i = base; i < cap_a.size(); i++) begin
      if (cap_a[i][31:12] == 20'h00012) begin
        chk($sformatf("fill%0d_addr", n_fill), cap_a[i], 32'h0001_2000 + 32'(4 * n_fill));
        chk($sformatf("fill%0d_data", n_fill), cap_d[i], 32'h5A5A_5A5A);
        if (first_f < 0) first_f = i;
        last_f = i;
        n_fill++;
      end else if (cap_a[i][31:12] == 20'h00013) begin
        k = int'((cap_a[i] - 32'h0001_3000) >> 2);
        chk($sformatf("cpu%0d_data", n_cpu), cap_d[i], 32'hC000_0000 + 32'(k));
        chk($sformatf("cpu%0d_order", n_cpu), 32'(k > last_k), 1);
        last_k = k;
        n_cpu++;
      end else begin
        n_other++;
      end
    end
    chk("stream_fill_beats", n_fill, 8);
    chk("stream_stray", n_other, 0);
    chk("stream_some_dropped", 32'(n_cpu < 14), 1);
    chk("stream_cpu_progress", 32'(n_cpu >= 8), 1);
    bad = 0;
    if (first_f >= 0) begin
      src_prev = 1'b1;
      for (int i = first_f + 1; i <= last_f; i++) begin
        src_cur = (cap_a[i][31:12] == 20'h00012);
        if (src_cur == src_prev) bad++;
        src_prev = src_cur;
      end
    end
    chk("stream_alternate", bad, 0);
    chk("stream_full_seen", 32'(full_cnt > fbase), 1);
    chk("stream_ovf", ovf, 1);
    chk("stream_busy_end", fill_busy, 0);
    chk("stream_full_end", fifo_full, 0);
    step(1'b1, 32'h0000_FF10, 32'h0);
    chk("ovf_clr", ovf, 0);

    // config writes while busy must not affect the next fill
    step(1'b1, 32'h0000_FF04, 32'h0000_0002);
    step(1'b1, 32'h0000_FF08, 32'h1111_1111);
    base = cap_a.size();
    step(1'b1, 32'h0000_FF0C, 32'h0);
    chk("cfg_busy_go", fill_busy, 1);
    step(1'b1, 32'h0000_FF00, 32'h0001_9000);
    step(1'b1, 32'h0000_FF08, 32'h2222_2222);
    chk("cfg_busy_done", fill_busy, 0);
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_FF0C, 32'h0);
    for (int j = 0; j < 4; j++) step(1'b0, 32'h0, 32'h0);
    chk("cfg_count", cap_a.size() - base, 4);
    for (int i = 0; i < 4 && base + i < cap_a.size(); i++) begin
      chk($sformatf("cfg%0d_addr", i), cap_a[base + i], (i % 2 == 1) ? 32'h0001_2004 : 32'h0001_2000);
      chk($sformatf("cfg%0d_data", i), cap_d[base + i], 32'h1111_1111);
    end

    // asynchronous reset in the middle of a fill with stores queued
    step(1'b1, 32'h0000_FF04, 32'h0000_0008);
    step(1'b1, 32'h0000_FF0C, 32'h0);
    step(1'b1, 32'h0001_3100, 32'hBEEF_0000);
    step(1'b1, 32'h0001_3104, 32'hBEEF_0001);
    step(1'b0, 32'h0, 32'h0);
    #2;
    chk("pre_rst_web", mem_web, 1);
    chk("pre_rst_busy", fill_busy, 1);
    RST = 1'b1;
    #1 chk_zero("mid_rst");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    base = cap_a.size();
    for (int j = 0; j < 10; j++) step(1'b0, 32'h0, 32'h0);
    chk("post_rst_writes", cap_a.size() - base, 0);
    chk_zero("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
